// File: rtl/inv_mixcolumns_iter.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place, then presents the result.
// Ports: clk, reset_n (async, active-low),
//        in_valid/in_ready/in_data (input handshake),
//        out_valid/out_ready/out_data (output handshake),
//        busy (high while columns are being transformed).
module inv_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCYC = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST = 2'(NCYC - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
        COLS_PER_CYCLE != 4) begin : g_bad_cpc
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t       state_q;
    logic [1:0]   cnt_q;
    logic [127:0] data_q;
    logic [127:0] data_x;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [31:0]  col_q [4];
    logic [31:0]  col_d [4];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by x^n, n in 0..3, as a chain of xtime steps.
    function automatic logic [7:0] xn(input logic [7:0] b,
                                      input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (i < n) r = xtime(r);
        end
        return r;
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xn(b, 3) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xn(b, 3) ^ xn(b, 1) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xn(b, 3) ^ xn(b, 2) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xn(b, 3) ^ xn(b, 2) ^ xn(b, 1);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
        b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
        b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
        b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
        return {b0, b1, b2, b3};
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign col_q[c] = data_q[127-32*c -: 32];
        assign data_x[127-32*c -: 32] = col_d[c];
    end

    // Only the current column group goes through the GF datapath;
    // the others pass through unchanged.
    always_comb begin
        logic [1:0] grp;
        logic [1:0] idx;
        col_d = col_q;
        grp   = 2'(cnt_q * COLS_PER_CYCLE);
        idx   = grp;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            idx        = grp + 2'(g);
            col_d[idx] = inv_col(col_q[idx]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        cnt_q      <= '0;
                        state_q    <= BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                BUSY: begin
                    data_q <= data_x;
                    if (cnt_q == LAST) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Bench for inv_mixcolumns_iter: three instances (1, 2 and 4 columns
// per clock) checked against a GF(2^8) matrix reference model.
module tb_inv_mixcolumns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   iv, ir, ov, ordy, bz;
    logic [127:0] id [3];
    logic [127:0] od [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inv_mixcolumns_iter #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .reset_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .busy(bz[0])
    );

    inv_mixcolumns_iter #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .reset_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .busy(bz[1])
    );

    inv_mixcolumns_iter #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .reset_n(rst_n),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .busy(bz[2])
    );

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input int k,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (inst %0d): got %h want %h",
                     nm, k, act, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) product, reduced by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_imc(input logic [127:0] s);
        logic [7:0]   a [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        coef[0] = 8'h0e;
        coef[1] = 8'h0b;
        coef[2] = 8'h0d;
        coef[3] = 8'h09;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], a[4*c+j]);
                r[127-8*(4*c+row) -: 8] = acc;
            end
        return r;
    endfunction

    function automatic int ncyc(input int k);
        return 4 >> k;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic xact(input int k, input logic [127:0] d,
                        input logic [127:0] e);
        int n;
        @(negedge clk);
        iv[k]   = 1'b1;
        id[k]   = d;
        ordy[k] = 1'b0;
        chk("in_ready idle", k, 128'(ir[k]), 128'd1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        chk("busy after accept", k, 128'(bz[k]), 128'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ov[k] && n < 20);
        chk("latency", k, 128'(n), 128'(ncyc(k)));
        chk("result", k, od[k], e);
        chk("in_ready in done", k, 128'(ir[k]), 128'd0);
        @(negedge clk);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        chk("valid drop", k, 128'(ov[k]), 128'd0);
        chk("in_ready back", k, 128'(ir[k]), 128'd1);
        chk("data hold idle", k, od[k], e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a_in, a_ex, b_in, b_ex, r;
        int ac [2];
        int acc, res;
        logic acc_now;

        tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6,
                   128'hdb135345_f20a225c_01010101_d4d4d4d5};
        tbl[1] = '{128'h4d7ebdf8_c6c6c6c6_01010101_d5d5d7d6,
                   128'h2d26314c_c6c6c6c6_01010101_d4d4d4d5};
        tbl[2] = '{128'h0, 128'h0};
        tbl[3] = '{{4{32'hffffffff}}, {4{32'hffffffff}}};
        r = rnd128();
        tbl[4] = '{r, ref_imc(r)};
        r = rnd128();
        tbl[5] = '{r, ref_imc(r)};

        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        for (int k = 0; k < 3; k++) id[k] = '0;

        #12;
        for (int k = 0; k < 3; k++) begin
            chk("reset in_ready", k, 128'(ir[k]), 128'd1);
            chk("reset out_valid", k, 128'(ov[k]), 128'd0);
            chk("reset busy", k, 128'(bz[k]), 128'd0);
            chk("reset out_data", k, od[k], 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 6; i++)
                xact(k, tbl[i].din, tbl[i].dout);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++) begin
                r = rnd128();
                xact(k, r, ref_imc(r));
            end

        // Backpressure plus ignored input during BUSY and DONE.
        a_in = tbl[0].din;
        a_ex = tbl[0].dout;
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = a_in;
        @(posedge clk);
        #1;
        id[0] = ~a_in;
        for (int n = 0; n < 20 && !ov[0]; n++) begin
            @(posedge clk);
            #1;
        end
        chk("bp valid", 0, 128'(ov[0]), 128'd1);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            chk("bp hold valid", 0, 128'(ov[0]), 128'd1);
            chk("bp hold data", 0, od[0], a_ex);
            chk("bp in_ready", 0, 128'(ir[0]), 128'd0);
        end
        @(negedge clk);
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        chk("bp release ready", 0, 128'(ir[0]), 128'd1);
        chk("bp release valid", 0, 128'(ov[0]), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("no extra accept", 0, 128'(bz[0]), 128'd0);
        chk("still idle", 0, 128'(ir[0]), 128'd1);

        // Back-to-back with in_valid and out_ready held high.
        b_in = {32'h4d7ebdf8, rnd128()};
        b_in = {32'h4d7ebdf8, b_in[95:0]};
        b_ex = ref_imc(b_in);
        ac[0] = 0;
        ac[1] = 0;
        acc   = 0;
        res   = 0;
        @(negedge clk);
        iv[0]   = 1'b1;
        id[0]   = a_in;
        ordy[0] = 1'b1;
        for (int cyc = 0; cyc < 40 && res < 2; cyc++) begin
            acc_now = ir[0] && iv[0];
            if (ov[0]) begin
                chk("b2b result", 0, od[0], (res == 0) ? a_ex : b_ex);
                if (res == 1)
                    chk("b2b col0", 0, 128'(od[0][127:96]),
                        128'h2d26314c);
                res++;
            end
            @(posedge clk);
            #1;
            if (acc_now) begin
                if (acc < 2) ac[acc] = cyc;
                acc++;
                if (acc == 1) id[0] = b_in;
                else iv[0] = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b results", 0, 128'(res), 128'd2);
        chk("b2b accepts", 0, 128'(acc), 128'd2);
        chk("b2b interval", 0, 128'(ac[1] - ac[0]), 128'd6);
        @(posedge clk);
        #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b0;

        // Reset after two processed columns.
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = rnd128();
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", 0, 128'(ir[0]), 128'd1);
        chk("mid rst out_valid", 0, 128'(ov[0]), 128'd0);
        chk("mid rst busy", 0, 128'(bz[0]), 128'd0);
        chk("mid rst out_data", 0, od[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no stale valid", 0, 128'(ov[0]), 128'd0);
        end
        r = rnd128();
        xact(0, r, ref_imc(r));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
